uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Bus-master front end for the UART register block.
- Shares the UART transmitter among NUM_REQ byte producers, e.g. CPU console and debug/trace. Each producer has its own small FIFO.
- Round-robin arbitration between producers.
- Sequences the UART register protocol itself: enable TX once, poll STATUS.tx_busy, write TXDATA. Producers never touch UART registers.

Parameters:
- NUM_REQ, 2, number of byte producers (1..4).
- FIFO_DEPTH, 4, bytes per producer FIFO (power of 2, >=2).
- BASE_ADDR, 32'h3000_0000, UART base address; register offsets are added to it.
- RX_EN, 1'b0, value written to UART_CTRL bit[1] during init.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid_i  in  NUM_REQ  per-producer byte valid
- req_data_i  in  8*NUM_REQ  per-producer byte; producer k uses bits [8k+7:8k]
- req_ready_o  out  NUM_REQ  per-producer FIFO not full
- uart_we_o  out  1  UART register write strobe
- uart_addr_o  out  32  UART register address
- uart_data_o  out  32  UART write data
- uart_sel_o  out  4  byte select
- uart_data_i  in  32  UART read data (combinational from address)
- busy_o  out  1  any FIFO non-empty or a transfer in flight
- grant_o  out  NUM_REQ  one-hot producer currently being served

Behaviour:
- Reset, applied while rst==0:
  - FIFOs are emptied.
  - FSM goes to S_INIT.
  - RR pointer is set so producer 0 has first priority.
  - uart_we_o=0, uart_addr_o=0, uart_data_o=0, uart_sel_o=0, grant_o=0, busy_o=0, req_ready_o=0.
- Reset asserted mid-transfer: the byte in flight and all queued bytes are discarded. No partial write is issued.
- Producer handshake:
  - A byte is pushed at a clock edge where req_valid_i[k]&&req_ready_o[k].
  - req_ready_o[k] = !full[k], evaluated from the registered count. A push and a pop on a full FIFO in the same cycle: the push is refused.
  - A byte pushed at edge t is visible as non-empty from cycle t+1.
- FSM states (one-hot):
  - S_INIT: one cycle. Write UART_CTRL (BASE+0x0) with {30'b0,RX_EN,1'b1}, sel=4'b0001. Then go to S_IDLE.
  - S_IDLE: if any FIFO is non-empty, grant the first non-empty producer searching from last_grant+1 modulo NUM_REQ. Register the grant and go to S_POLL. Otherwise stay.
  - S_POLL: addr=BASE+0x4, we=0. If uart_data_i[0]==0, go to S_WRITE; else stay (unbounded wait).
  - S_WRITE: one cycle.
    - we=1, addr=BASE+0xC, data={24'h0,fifo_head}, sel=4'b0001.
    - Pop the granted FIFO and update last_grant.
    - Go to S_GAP.
  - S_GAP: one cycle with we=0, so the UART clears its tx_data_valid and has already set tx_busy. Clear grant_o and go to S_IDLE.
- Outputs: uart_* outputs are a combinational decode of state and grant. In S_IDLE/S_GAP they are addr=BASE+0x4, data=0, sel=0, we=0.
- Latency: UART idle, FSM in S_IDLE, push at edge t → uart_we_o=1 in the cycle following edge t+2, i.e. 3 cycles.
- Throughput: one byte per UART frame. Scheduler overhead is at most 3 cycles per byte beyond the frame.
- Fairness: when all producers are non-empty, grants rotate strictly 0,1,..,N-1,0. No producer waits more than NUM_REQ-1 bytes.
- FIFO pointers: log2(FIFO_DEPTH)-bit, wrap naturally. Count is log2(FIFO_DEPTH)+1 bits. Simultaneous push+pop on a non-full, non-empty FIFO leaves count unchanged.
- busy_o = (state!=S_IDLE && state!=S_INIT) || any FIFO non-empty.

Decomposition:
- Shared package uart_pkg:
  - UART register offsets: CTRL 0x0, STATUS 0x4, BAUD 0x8, TXDATA 0xC, RXDATA 0x10.
  - Bit indices: CTRL_TX_EN=0, CTRL_RX_EN=1, STAT_TX_BUSY=0, STAT_RX_OVER=1.
  - Scheduler state encodings.
- Sub-module uart_byte_fifo (8-bit synchronous FIFO, DEPTH param; push/pop/full/empty/head), instantiated NUM_REQ times via generate. Arbitration and FSM live in the top module.

Test Plan:
- Reset then release → exactly one write, CTRL=0x00000001 at 0x3000_0000, sel=0001, then S_IDLE with uart_we_o=0.
- Producer 0 pushes 0x55 with the UART model idle → TXDATA write of 0x00000055 three cycles after the push edge. busy_o drops after S_GAP.
- Both producers pre-filled (P0: 0xA0,0xA1; P1: 0xB0,0xB1) → TXDATA order A0,B0,A1,B1, with grant_o alternating 01,10,01,10.
- UART model holds STATUS[0]=1 for 500 cycles → FSM stays in S_POLL, no writes. A single write follows on release.
- Push 5 bytes into producer 1 with the UART busy → req_ready_o[1] falls after the 4th push. The 5th byte is held by the producer and accepted after the first pop. All 5 bytes are transmitted in order.
- Assert rst during S_POLL with 3 bytes queued → all outputs return to reset values. After release: only the CTRL init write, no TXDATA writes.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, bit indices and TX scheduler state encodings.
package uart_pkg;

  localparam logic [31:0] UART_CTRL_OFS   = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;
  localparam logic [31:0] UART_BAUD_OFS   = 32'h0000_0008;
  localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_000C;
  localparam logic [31:0] UART_RXDATA_OFS = 32'h0000_0010;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int STAT_TX_BUSY = 0;
  localparam int STAT_RX_OVER = 1;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_IDLE  = 5'b00010,
    S_POLL  = 5'b00100,
    S_WRITE = 5'b01000,
    S_GAP   = 5'b10000
  } sched_state_t;

  function automatic logic [31:0] ctrl_word(input logic rx_en);
    logic [31:0] w;
    w             = '0;
    w[CTRL_TX_EN] = 1'b1;
    w[CTRL_RX_EN] = rx_en;
    return w;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - Small synchronous byte FIFO; push on full is refused even with a concurrent pop.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - Round-robin arbiter feeding several byte producers into one UART transmitter.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic        RX_EN      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 uart_we_o,
  output logic [31:0]          uart_addr_o,
  output logic [31:0]          uart_data_o,
  output logic [3:0]           uart_sel_o,
  input  logic [31:0]          uart_data_i,
  output logic                 busy_o,
  output logic [NUM_REQ-1:0]   grant_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state;
  sched_state_t       state_next;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] pop;
  logic [7:0]         heads [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_found;
  logic               unused_status;

  assign unused_status = ^uart_data_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
    uart_byte_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (req_valid_i[k]),
      .pop  (pop[k]),
      .data (req_data_i[8*k +: 8]),
      .full (full[k]),
      .empty(empty[k]),
      .head (heads[k])
    );
  end

  // Search starts just after the last producer served, so a busy producer cannot starve the others.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!sel_found && !empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (state == S_WRITE) begin
      pop[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_INIT;
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            grant     <= NUM_REQ'(1) << sel_idx;
            grant_idx <= sel_idx;
          end
        end
        S_WRITE: last_grant <= grant_idx;
        S_GAP:   grant      <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = S_IDLE;
      S_IDLE:  if (sel_found) state_next = S_POLL;
      S_POLL:  if (!uart_data_i[STAT_TX_BUSY]) state_next = S_WRITE;
      S_WRITE: state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Bus outputs are gated by rst so nothing, not even a partial write, appears while held in reset.
  always_comb begin
    uart_we_o   = 1'b0;
    uart_addr_o = BASE_ADDR + UART_STATUS_OFS;
    uart_data_o = '0;
    uart_sel_o  = '0;
    case (state)
      S_INIT: begin
        uart_we_o   = 1'b1;
        uart_addr_o = BASE_ADDR + UART_CTRL_OFS;
        uart_data_o = ctrl_word(RX_EN);
        uart_sel_o  = 4'b0001;
      end
      S_WRITE: begin
        uart_we_o   = 1'b1;
        uart_addr_o = BASE_ADDR + UART_TXDATA_OFS;
        uart_data_o = {24'h0, heads[grant_idx]};
        uart_sel_o  = 4'b0001;
      end
      default: ;
    endcase
    if (!rst) begin
      uart_we_o   = 1'b0;
      uart_addr_o = '0;
      uart_data_o = '0;
      uart_sel_o  = '0;
    end
  end

  assign grant_o     = rst ? grant : '0;
  assign req_ready_o = rst ? ~full : '0;
  assign busy_o      = rst && (((state != S_IDLE) && (state != S_INIT)) || !(&empty));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - Directed self-checking bench for uart_tx_scheduler.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        uart_we;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_sel;
  logic [31:0] uart_rdata;
  logic        busy;
  logic [1:0]  grant;
  logic        uart_busy;

  int checks;
  int failures;

  logic [31:0] log_addr  [$];
  logic [31:0] log_data  [$];
  logic [1:0]  log_grant [$];

  uart_tx_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .uart_we_o  (uart_we),
    .uart_addr_o(uart_addr),
    .uart_data_o(uart_wdata),
    .uart_sel_o (uart_sel),
    .uart_data_i(uart_rdata),
    .busy_o     (busy),
    .grant_o    (grant)
  );

  assign uart_rdata = {31'b0, uart_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor samples mid-low-phase, after the bench has driven its inputs.
  always begin
    @(negedge clk);
    #2;
    if (uart_we) begin
      log_addr.push_back(uart_addr);
      log_data.push_back(uart_wdata);
      log_grant.push_back(grant);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_grant.delete();
  endtask

  task automatic push(input int k, input logic [7:0] b);
    req_valid    = '0;
    req_valid[k] = 1'b1;
    req_data[8*k +: 8] = b;
    tick();
    req_valid = '0;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'b0, uart_we}, 32'h0);
    chk({tag, "_addr"},  uart_addr,        32'h0);
    chk({tag, "_data"},  uart_wdata,       32'h0);
    chk({tag, "_sel"},   {28'b0, uart_sel}, 32'h0);
    chk({tag, "_grant"}, {30'b0, grant},   32'h0);
    chk({tag, "_busy"},  {31'b0, busy},    32'h0);
    chk({tag, "_ready"}, {30'b0, req_ready}, 32'h0);
  endtask

  logic [7:0] exp_tx [5];
  logic [1:0] exp_gr [4];
  int         accepted;
  int         n;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    uart_busy = 1'b0;

    // Reset state and the single CTRL init write.
    ticks(3);
    chk_reset_outputs("rst");
    clear_log();
    rst = 1'b1;
    #1;
    chk("init_we",   {31'b0, uart_we},  32'h1);
    chk("init_addr", uart_addr,         32'h3000_0000);
    chk("init_data", uart_wdata,        32'h0000_0001);
    chk("init_sel",  {28'b0, uart_sel}, 32'h1);
    tick();
    chk("idle_we",   {31'b0, uart_we},  32'h0);
    chk("idle_addr", uart_addr,         32'h3000_0004);
    chk("idle_busy", {31'b0, busy},     32'h0);
    chk("idle_ready", {30'b0, req_ready}, 32'h3);
    ticks(5);
    chk("init_count", log_addr.size(), 1);

    // Single byte latency: write appears in the cycle after edge t+2.
    clear_log();
    push(0, 8'h55);
    chk("lat_t0_we",   {31'b0, uart_we}, 32'h0);
    chk("lat_t0_busy", {31'b0, busy},    32'h1);
    tick();
    chk("lat_t1_we",    {31'b0, uart_we}, 32'h0);
    chk("lat_t1_grant", {30'b0, grant},   32'h1);
    tick();
    chk("lat_t2_we",   {31'b0, uart_we},  32'h1);
    chk("lat_t2_addr", uart_addr,         32'h3000_000C);
    chk("lat_t2_data", uart_wdata,        32'h0000_0055);
    chk("lat_t2_sel",  {28'b0, uart_sel}, 32'h1);
    tick();
    chk("gap_we",   {31'b0, uart_we}, 32'h0);
    chk("gap_busy", {31'b0, busy},    32'h1);
    tick();
    chk("post_busy",  {31'b0, busy},  32'h0);
    chk("post_grant", {30'b0, grant}, 32'h0);

    // Round-robin: P0 A0 first, then A1/B0 together, then B1.
    clear_log();
    uart_busy = 1'b1;
    push(0, 8'hA0);
    req_valid = 2'b11;
    req_data  = {8'hB0, 8'hA1};
    tick();
    req_valid = '0;
    push(1, 8'hB1);
    uart_busy = 1'b0;
    ticks(40);
    exp_tx[0] = 8'hA0; exp_tx[1] = 8'hB0; exp_tx[2] = 8'hA1; exp_tx[3] = 8'hB1;
    exp_gr[0] = 2'b01; exp_gr[1] = 2'b10; exp_gr[2] = 2'b01; exp_gr[3] = 2'b10;
    chk("rr_count", log_data.size(), 4);
    n = (log_data.size() < 4) ? log_data.size() : 4;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_data%0d", i),  log_data[i],  {24'h0, exp_tx[i]});
      chk($sformatf("rr_grant%0d", i), {30'b0, log_grant[i]}, {30'b0, exp_gr[i]});
      chk($sformatf("rr_addr%0d", i),  log_addr[i],  32'h3000_000C);
    end

    // Long busy: FSM waits in POLL without writing.
    clear_log();
    uart_busy = 1'b1;
    push(0, 8'h77);
    ticks(500);
    chk("hold_count", log_addr.size(), 0);
    chk("hold_grant", {30'b0, grant}, 32'h1);
    chk("hold_addr",  uart_addr, 32'h3000_0004);
    chk("hold_we",    {31'b0, uart_we}, 32'h0);
    uart_busy = 1'b0;
    ticks(10);
    chk("hold_rel_count", log_addr.size(), 1);
    if (log_data.size() > 0) chk("hold_rel_data", log_data[0], 32'h0000_0077);

    // Backpressure: fifth byte into P1 waits for the first pop.
    clear_log();
    uart_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 8'hC0 + 8'(i));
    chk("bp_ready1", {31'b0, req_ready[1]}, 32'h0);
    chk("bp_ready0", {31'b0, req_ready[0]}, 32'h1);
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'hC4;
    uart_busy = 1'b0;
    accepted = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[1]) begin
        tick();
        accepted = 1;
        break;
      end
      tick();
    end
    req_valid = '0;
    chk("bp_accepted", accepted, 1);
    ticks(40);
    chk("bp_count", log_data.size(), 5);
    n = (log_data.size() < 5) ? log_data.size() : 5;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("bp_data%0d", i), log_data[i], {24'h0, 8'hC0 + 8'(i)});
    end

    // Reset during POLL discards queued bytes.
    clear_log();
    uart_busy = 1'b1;
    push(0, 8'hD0);
    push(0, 8'hD1);
    push(0, 8'hD2);
    ticks(2);
    chk("mid_grant", {30'b0, grant}, 32'h1);
    chk("mid_busy",  {31'b0, busy},  32'h1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    ticks(2);
    clear_log();
    uart_busy = 1'b0;
    rst = 1'b1;
    ticks(20);
    chk("mid_count", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("mid_addr", log_addr[0], 32'h3000_0000);
      chk("mid_data", log_data[0], 32'h0000_0001);
    end
    chk("mid_end_busy", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
